// File: rtl/complex_multiplier_pipe.sv
// complex_multiplier_pipe
//   Valid-tagged 3-stage pipelined complex multiplier for the FFT butterfly:
//   (a + bi) * (c + di), with c + di the twiddle. The twiddle may optionally
//   be conjugated per sample (IFFT direction).
//
//   Stage 1 : four full-precision signed products ac, bd, ad, bc (registered)
//   Stage 2 : 2W+1-bit sum/difference plus rounding constant (registered)
//   Stage 3 : arithmetic shift by F, saturate or wrap, overflow flag (registered)
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_en                pipeline advance; 0 holds every pipeline register
//   i_valid, i_conj     sample valid, conjugate-twiddle select
//   i_tag               sideband carried alongside the sample
//   i_data_re/im        a, b  (signed W)
//   i_tw_re/im          c, d  (signed W)
//   i_clr_ovf           clears the sticky overflow (works while stalled)
//   o_valid, o_tag      output valid and its tag
//   o_re, o_im          result components (signed W)
//   o_ovf               overflow of either component, aligned with o_valid
//   o_ovf_sticky        sticky OR of o_ovf since reset / last clear

// One result component: x +/- y, round, shift, clamp. Real uses (ac, bd),
// imaginary uses (bc, ad); the conjugate only flips which one subtracts, so
// d = -2^(W-1) never has to be negated.
module complex_multiplier_lane #(
  parameter int W   = 16,
  parameter int F   = 15,
  parameter int RND = 1,
  parameter int SAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic           i_vld,      // stage-2 valid, qualifies the flag
  input  logic           i_sub,      // 1: x - y, 0: x + y
  input  logic [2*W-1:0] i_px,
  input  logic [2*W-1:0] i_py,
  output logic [W-1:0]   o_res,
  output logic           o_ovf,      // registered, valid-qualified
  output logic           o_ovf_nxt   // value o_ovf takes at the next edge
);
  localparam int SW = 2*W + 1;
  localparam logic [SW-1:0] RND_K = (RND != 0) ? (SW'(1) << (F-1)) : '0;
  localparam logic [W-1:0]  MAXV  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MINV  = {1'b1, {(W-1){1'b0}}};

  logic signed [SW-1:0] x_ext, y_ext, sum_d, sum_q, shr;
  logic [SW-W:0]        hi;
  logic                 ovf_c;
  logic [W-1:0]         res_c;

  assign x_ext = $signed({i_px[2*W-1], i_px});
  assign y_ext = $signed({i_py[2*W-1], i_py});
  // Rounding constant is folded in after the full-precision sum so that
  // round-half-up applies to the exact result, not to each product.
  assign sum_d = (i_sub ? (x_ext - y_ext) : (x_ext + y_ext)) + $signed(RND_K);

  always_ff @(posedge i_clk) begin
    if (i_rst)     sum_q <= '0;
    else if (i_en) sum_q <= sum_d;
  end

  assign shr = sum_q >>> F;
  // In range iff every bit from the W-bit sign position upward agrees.
  assign hi        = shr[SW-1:W-1];
  assign ovf_c     = !((&hi) || !(|hi));
  assign res_c     = (SAT != 0 && ovf_c) ? (shr[SW-1] ? MINV : MAXV) : shr[W-1:0];
  assign o_ovf_nxt = i_vld & ovf_c;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_res <= '0;
      o_ovf <= 1'b0;
    end else if (i_en) begin
      o_res <= res_c;
      o_ovf <= o_ovf_nxt;
    end
  end
endmodule

module complex_multiplier_pipe #(
  parameter int W     = 16,
  parameter int F     = 15,
  parameter int TAG_W = 8,
  parameter int RND   = 1,
  parameter int SAT   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic             i_conj,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [W-1:0]     i_data_re,
  input  logic [W-1:0]     i_data_im,
  input  logic [W-1:0]     i_tw_re,
  input  logic [W-1:0]     i_tw_im,
  input  logic             i_clr_ovf,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [W-1:0]     o_re,
  output logic [W-1:0]     o_im,
  output logic             o_ovf,
  output logic             o_ovf_sticky
);
  localparam int STAGES = 3;
  localparam int NL     = 2;   // lane 0 = real, lane 1 = imaginary

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:1][TAG_W-1:0]  tag_pipe;
  logic                        conj_q;
  logic signed [2*W-1:0]       p_ac, p_bd, p_ad, p_bc;

  logic [NL-1:0][2*W-1:0]      px, py;
  logic [NL-1:0]               sub;
  logic [NL-1:0][W-1:0]        res;
  logic [NL-1:0]               ovf_q, ovf_nxt;

  // Valid and tag shift alongside the data; bubbles move like samples.
  assign vld_pipe[0] = i_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe[STAGES:1] <= '0;
      tag_pipe           <= '0;
    end else if (i_en) begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      tag_pipe           <= {tag_pipe[STAGES-1:1], i_tag};
    end
  end

  // Stage 1: bare registered multiplies straight off the ports so each maps
  // onto a DSP block with its output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_ac   <= '0;
      p_bd   <= '0;
      p_ad   <= '0;
      p_bc   <= '0;
      conj_q <= 1'b0;
    end else if (i_en) begin
      p_ac   <= (2*W)'($signed(i_data_re)) * (2*W)'($signed(i_tw_re));
      p_bd   <= (2*W)'($signed(i_data_im)) * (2*W)'($signed(i_tw_im));
      p_ad   <= (2*W)'($signed(i_data_re)) * (2*W)'($signed(i_tw_im));
      p_bc   <= (2*W)'($signed(i_data_im)) * (2*W)'($signed(i_tw_re));
      conj_q <= i_conj;
    end
  end

  // re: conj ? ac + bd : ac - bd      im: conj ? bc - ad : bc + ad
  assign px[0]  = p_ac;
  assign py[0]  = p_bd;
  assign sub[0] = ~conj_q;
  assign px[1]  = p_bc;
  assign py[1]  = p_ad;
  assign sub[1] = conj_q;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    complex_multiplier_lane #(.W(W), .F(F), .RND(RND), .SAT(SAT)) u_lane (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_vld     (vld_pipe[2]),
      .i_sub     (sub[g]),
      .i_px      (px[g]),
      .i_py      (py[g]),
      .o_res     (res[g]),
      .o_ovf     (ovf_q[g]),
      .o_ovf_nxt (ovf_nxt[g])
    );
  end

  assign o_valid = vld_pipe[STAGES];
  assign o_tag   = tag_pipe[STAGES];
  assign o_re    = res[0];
  assign o_im    = res[1];
  assign o_ovf   = |ovf_q;

  // Sticky rises on the same edge as o_ovf. Clear is not gated by i_en, and
  // a coincident set beats the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst)                    o_ovf_sticky <= 1'b0;
    else if (i_en && (|ovf_nxt))  o_ovf_sticky <= 1'b1;
    else if (i_clr_ovf)           o_ovf_sticky <= 1'b0;
  end
endmodule

// File: tb/tb_complex_multiplier_pipe.sv
module tb_complex_multiplier_pipe;
  localparam int W = 16;
  localparam int F = 15;
  localparam int TAG_W = 8;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic             i_rst, i_en, i_valid, i_conj, i_clr_ovf;
  logic [TAG_W-1:0] i_tag;
  logic [W-1:0]     i_data_re, i_data_im, i_tw_re, i_tw_im;

  logic             d_valid, d_ovf, d_sticky, a_valid, a_ovf, a_sticky;
  logic [TAG_W-1:0] d_tag, a_tag;
  logic [W-1:0]     d_re, d_im, a_re, a_im;

  // Default build: round + saturate
  complex_multiplier_pipe #(.W(W), .F(F), .TAG_W(TAG_W), .RND(1), .SAT(1)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid), .i_conj(i_conj),
    .i_tag(i_tag), .i_data_re(i_data_re), .i_data_im(i_data_im), .i_tw_re(i_tw_re),
    .i_tw_im(i_tw_im), .i_clr_ovf(i_clr_ovf), .o_valid(d_valid), .o_tag(d_tag),
    .o_re(d_re), .o_im(d_im), .o_ovf(d_ovf), .o_ovf_sticky(d_sticky));

  // Alternate build: truncate + wrap, same stimulus
  complex_multiplier_pipe #(.W(W), .F(F), .TAG_W(TAG_W), .RND(0), .SAT(0)) u_alt (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid), .i_conj(i_conj),
    .i_tag(i_tag), .i_data_re(i_data_re), .i_data_im(i_data_im), .i_tw_re(i_tw_re),
    .i_tw_im(i_tw_im), .i_clr_ovf(i_clr_ovf), .o_valid(a_valid), .o_tag(a_tag),
    .o_re(a_re), .o_im(a_im), .o_ovf(a_ovf), .o_ovf_sticky(a_sticky));

  typedef struct {
    logic             valid;
    logic             conj;
    logic [TAG_W-1:0] tag;
    int               a, b, c, d;
  } samp_t;

  typedef struct {
    int a, b, c, d;
    bit conj;
    int re, im;
    bit ovf;
    int re_alt, im_alt;
  } vec_t;

  samp_t            hist[$];   // last three accepted samples, oldest = output
  logic [TAG_W-1:0] seen[$];
  bit               collect = 0;
  bit               m_sticky_d, m_sticky_a;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, floor shift, then clamp or wrap.
  function automatic void fix(input longint v_in, input bit rnd, input bit sat,
                              output logic [W-1:0] r, output bit o);
    longint v, q, lim;
    v   = v_in;
    lim = longint'(1) << (W-1);
    if (rnd) v = v + (longint'(1) << (F-1));
    q = v >>> F;
    o = (q > lim - 1) || (q < -lim);
    if (o && sat) q = (q > 0) ? lim - 1 : -lim;
    r = q[W-1:0];
  endfunction

  function automatic void ref_calc(input samp_t s, input bit rnd, input bit sat,
                                   output logic [W-1:0] re, output logic [W-1:0] im,
                                   output bit ovf);
    longint ac, bd, ad, bc, sr, si;
    bit orr, oii;
    ac = longint'(s.a) * s.c;
    bd = longint'(s.b) * s.d;
    ad = longint'(s.a) * s.d;
    bc = longint'(s.b) * s.c;
    sr = s.conj ? ac + bd : ac - bd;
    si = s.conj ? bc - ad : ad + bc;
    fix(sr, rnd, sat, re, orr);
    fix(si, rnd, sat, im, oii);
    ovf = orr | oii;
  endfunction

  function automatic samp_t zero_samp();
    samp_t z;
    z.valid = 0; z.conj = 0; z.tag = '0;
    z.a = 0; z.b = 0; z.c = 0; z.d = 0;
    return z;
  endfunction

  task automatic compare_all();
    logic [W-1:0] re, im;
    bit ov;
    samp_t s;
    s = hist[0];
    ref_calc(s, 1, 1, re, im, ov);
    chk("d_valid", d_valid, s.valid);
    chk("d_tag", d_tag, s.tag);
    chk("d_re", $signed(d_re), $signed(re));
    chk("d_im", $signed(d_im), $signed(im));
    chk("d_ovf", d_ovf, s.valid & ov);
    chk("d_sticky", d_sticky, m_sticky_d);
    ref_calc(s, 0, 0, re, im, ov);
    chk("a_valid", a_valid, s.valid);
    chk("a_tag", a_tag, s.tag);
    chk("a_re", $signed(a_re), $signed(re));
    chk("a_im", $signed(a_im), $signed(im));
    chk("a_ovf", a_ovf, s.valid & ov);
    chk("a_sticky", a_sticky, m_sticky_a);
  endtask

  // One clock: capture what the DUT samples, advance the model, check outputs.
  task automatic cyc();
    samp_t cur, o;
    bit r, e, c, sd, sa, od, oa;
    logic [W-1:0] t0, t1;
    cur.valid = i_valid; cur.conj = i_conj; cur.tag = i_tag;
    cur.a = int'($signed(i_data_re)); cur.b = int'($signed(i_data_im));
    cur.c = int'($signed(i_tw_re));   cur.d = int'($signed(i_tw_im));
    r = i_rst; e = i_en; c = i_clr_ovf;
    @(posedge i_clk);
    if (r) begin
      hist.delete();
      repeat (3) hist.push_back(zero_samp());
      m_sticky_d = 0;
      m_sticky_a = 0;
    end else begin
      sd = 0; sa = 0;
      if (e) begin
        hist.push_back(cur);
        void'(hist.pop_front());
        o = hist[0];
        ref_calc(o, 1, 1, t0, t1, od);
        ref_calc(o, 0, 0, t0, t1, oa);
        sd = o.valid && od;
        sa = o.valid && oa;
        if (collect && o.valid) seen.push_back(o.tag);
      end
      if (sd) m_sticky_d = 1; else if (c) m_sticky_d = 0;
      if (sa) m_sticky_a = 1; else if (c) m_sticky_a = 0;
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input int a, input int b, input int c, input int d, input bit cj);
    i_data_re = W'(a); i_data_im = W'(b); i_tw_re = W'(c); i_tw_im = W'(d); i_conj = cj;
  endtask

  function automatic int rnd_val();
    int k;
    k = int'($urandom_range(0, 7));
    if (k == 0) return -32768;
    if (k == 1) return 32767;
    return int'($signed(16'($urandom)));
  endfunction

  vec_t tbl[8];
  logic [W-1:0]     snap_re;
  logic [TAG_W-1:0] snap_tag;
  logic             snap_v;

  initial begin
    tbl[0] = '{16384, 0, 16384, 0, 0,      8192,  0,     0,  8192,   0};
    tbl[1] = '{16384, 16384, 0, 16384, 0, -8192,  8192,  0, -8192,   8192};
    tbl[2] = '{16384, 16384, 0, 16384, 1,  8192, -8192,  0,  8192,  -8192};
    tbl[3] = '{-32768, 0, -32768, 0, 0,    32767, 0,     1, -32768,  0};
    tbl[4] = '{1, 0, 16384, 0, 0,          1,     0,     0,  0,      0};
    tbl[5] = '{-1, 0, 16384, 0, 0,         0,     0,     0, -1,      0};
    tbl[6] = '{0, 16384, 0, -32768, 0,     16384, 0,     0,  16384,  0};
    tbl[7] = '{0, 16384, 0, -32768, 1,    -16384, 0,     0, -16384,  0};

    i_rst = 1; i_en = 1; i_valid = 0; i_clr_ovf = 0; i_tag = '0;
    drive(0, 0, 0, 0, 0);
    cyc(); cyc();
    i_rst = 0;
    cyc();

    // Directed vectors with hand-computed results
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].conj);
      i_tag = TAG_W'(i + 16); i_valid = 1;
      cyc();
      i_valid = 0; drive(0, 0, 0, 0, 0);
      cyc(); cyc();
      chk("vec_valid", d_valid, 1);
      chk("vec_tag", d_tag, i + 16);
      chk("vec_re", $signed(d_re), tbl[i].re);
      chk("vec_im", $signed(d_im), tbl[i].im);
      chk("vec_ovf", d_ovf, tbl[i].ovf);
      chk("vec_alt_re", $signed(a_re), tbl[i].re_alt);
      chk("vec_alt_im", $signed(a_im), tbl[i].im_alt);
      chk("vec_alt_ovf", a_ovf, tbl[i].ovf);
      cyc();
      chk("vec_drain_valid", d_valid, 0);
      if (tbl[i].ovf) begin
        chk("ovf_pulse_end", d_ovf, 0);
        chk("sticky_held", d_sticky, 1);
        i_en = 0; cyc(); cyc(); i_en = 1;
        chk("sticky_held_stall", d_sticky, 1);
        i_en = 0; i_clr_ovf = 1; cyc(); i_clr_ovf = 0; i_en = 1;
        chk("sticky_clr_stalled", d_sticky, 0);
      end
    end

    // Set and clear on the same edge: set wins
    drive(-32768, 0, -32768, 0, 0); i_valid = 1; i_tag = 8'd99;
    cyc();
    i_valid = 0; drive(0, 0, 0, 0, 0);
    cyc();
    i_clr_ovf = 1; cyc(); i_clr_ovf = 0;
    chk("setclr_ovf", d_ovf, 1);
    chk("setclr_sticky", d_sticky, 1);
    i_clr_ovf = 1; cyc(); i_clr_ovf = 0;
    chk("setclr_after", d_sticky, 0);

    // Stream: tags 0..7, bubble at 3, 2-cycle stall before tag 5
    collect = 1; seen.delete();
    for (int t = 0; t < 8; t++) begin
      if (t == 5) begin
        snap_v = d_valid; snap_tag = d_tag; snap_re = d_re;
        i_en = 0; i_valid = 1; i_tag = 8'hEE; drive(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 0);
        for (int s = 0; s < 2; s++) begin
          cyc();
          chk("stall_valid", d_valid, snap_v);
          chk("stall_tag", d_tag, snap_tag);
          chk("stall_re", $signed(d_re), $signed(snap_re));
        end
        i_en = 1;
      end
      i_tag = TAG_W'(t); i_valid = (t != 3);
      drive(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'($urandom));
      cyc();
    end
    i_valid = 0;
    repeat (4) cyc();
    collect = 0;
    chk("stream_count", seen.size(), 7);
    begin
      int k = 0;
      for (int t = 0; t < 8; t++) begin
        if (t != 3) begin
          if (k < seen.size()) chk("stream_order", seen[k], t);
          k++;
        end
      end
    end

    // Reset with samples in flight; sticky set beforehand
    drive(-32768, 0, -32768, 0, 0); i_valid = 1;
    for (int t = 0; t < 3; t++) begin i_tag = TAG_W'(40 + t); cyc(); end
    chk("pre_rst_sticky", d_sticky, 1);
    i_rst = 1; i_tag = 8'd43;
    cyc();
    i_rst = 0; i_valid = 0;
    chk("rst_valid", d_valid, 0);
    chk("rst_re", $signed(d_re), 0);
    chk("rst_tag", d_tag, 0);
    chk("rst_ovf", d_ovf, 0);
    chk("rst_sticky", d_sticky, 0);
    for (int t = 0; t < 5; t++) begin
      cyc();
      chk("post_rst_valid", d_valid, 0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      i_rst     = ($urandom_range(0, 149) == 0);
      i_en      = ($urandom_range(0, 99) < 85);
      i_valid   = ($urandom_range(0, 99) < 75);
      i_clr_ovf = ($urandom_range(0, 19) == 0);
      i_tag     = TAG_W'($urandom);
      drive(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'($urandom));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
